// File: rtl/alu_seq_pkg.sv
// Shared types for the registered ALU core: operation codes, flag layout and FSM states.
package alu_seq_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_ADC  = 4'd1,
      OP_SUB  = 4'd2,
      OP_SBC  = 4'd3,
      OP_AND  = 4'd4,
      OP_OR   = 4'd5,
      OP_XOR  = 4'd6,
      OP_NOT  = 4'd7,
      OP_NAND = 4'd8,
      OP_NOR  = 4'd9,
      OP_SHL  = 4'd10,
      OP_SHR  = 4'd11,
      OP_ASR  = 4'd12,
      OP_LLI  = 4'd13,
      OP_MUL  = 4'd14,
      OP_RSVD = 4'd15
   } op_t;

   typedef struct packed {
      logic v;
      logic c;
      logic n;
      logic z;
   } flags_t;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_MUL_RUN = 1'b1
   } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier: one partial product per clock, WIDTH clocks after Load.
// Instantiated by alu_seq_core only when ALU_MUL_EN is defined.
module alu_mul_seq #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               Load,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               Busy,
   output logic               Done,
   output logic [2*WIDTH-1:0] Product
);

   localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [SHW-1:0]     cnt_q;
   logic               busy_q;

   // Product is the accumulator including the current iteration, so the
   // final value is available on the same edge that completes the last step.
   always_comb begin
      acc_d = acc_q;
      if (mplier_q[0]) begin
         acc_d = acc_q + mcand_q;
      end
   end

   assign Product = acc_d;
   assign Done    = busy_q && (cnt_q == LAST_ITER);
   assign Busy    = busy_q;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else if (Load && !busy_q) begin
         mcand_q  <= {{WIDTH{1'b0}}, A};
         mplier_q <= B;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b1;
      end else if (busy_q) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + 1'b1;
         if (cnt_q == LAST_ITER) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq_core.sv
// Registered ALU with single-cycle arith/logic/shift/LLI ops and an optional
// iterative multiply (built only when ALU_MUL_EN is defined).
module alu_seq_core
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  op_t              Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [SHW-1:0]   ShAmt,
   input  logic             CIn,
   output logic             Ready,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] ALUOut,
   output logic [3:0]       Flags,
   output state_t           DbgState
);

   state_t state_q, state_d;
   logic [WIDTH-1:0] alu_out_q;
   flags_t           flags_q;
   logic             done_q;
   logic             alu_load;

   logic [WIDTH-1:0]          b_opd;
   logic                      carry_in;
   logic [WIDTH:0]            sum;
   logic                      ovf;
   logic [2*WIDTH-1:0]        shl_ext, shr_ext;
   logic signed [2*WIDTH-1:0] asr_ext;
   logic [WIDTH-1:0]          res;
   logic                      res_c, res_v;
   flags_t                    alu_flags;

   // SUB/SBC reuse the adder with an inverted B; C=1 then means no borrow.
   always_comb begin
      b_opd    = B;
      carry_in = 1'b0;
      case (Op)
         OP_ADC:  carry_in = CIn;
         OP_SUB: begin
            b_opd    = ~B;
            carry_in = 1'b1;
         end
         OP_SBC: begin
            b_opd    = ~B;
            carry_in = CIn;
         end
         default: ;
      endcase
   end

   assign sum = {1'b0, A} + {1'b0, b_opd} + {{WIDTH{1'b0}}, carry_in};
   assign ovf = (A[WIDTH-1] == b_opd[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);

   // Shifting into a double-width vector leaves the last bit shifted out at
   // the seam (bit WIDTH or WIDTH-1), which is zero when ShAmt is zero.
   assign shl_ext = {{WIDTH{1'b0}}, A} << ShAmt;
   assign shr_ext = {A, {WIDTH{1'b0}}} >> ShAmt;
   assign asr_ext = $signed({A, {WIDTH{1'b0}}}) >>> ShAmt;

   always_comb begin
      res   = '0;
      res_c = 1'b0;
      res_v = 1'b0;
      case (Op)
         OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
            res   = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
            res_v = ovf;
         end
         OP_AND:  res = A & B;
         OP_OR:   res = A | B;
         OP_XOR:  res = A ^ B;
         OP_NOT:  res = ~A;
         OP_NAND: res = ~(A & B);
         OP_NOR:  res = ~(A | B);
         OP_SHL: begin
            res   = shl_ext[WIDTH-1:0];
            res_c = shl_ext[WIDTH];
         end
         OP_SHR: begin
            res   = shr_ext[2*WIDTH-1:WIDTH];
            res_c = shr_ext[WIDTH-1];
         end
         OP_ASR: begin
            res   = asr_ext[2*WIDTH-1:WIDTH];
            res_c = asr_ext[WIDTH-1];
         end
         OP_LLI:  res = {A[WIDTH-1:WIDTH/2], B[WIDTH/2-1:0]};
         default: res = '0;
      endcase
   end

   assign alu_flags = '{v: res_v, c: res_c, n: res[WIDTH-1], z: (res == '0)};

`ifdef ALU_MUL_EN
   logic               mul_load;
   logic               mul_busy;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_prod;
   flags_t             mul_flags;

   alu_mul_seq #(.WIDTH(WIDTH), .SHW(SHW)) u_mul (
      .Clock   (Clock),
      .Reset   (Reset),
      .Load    (mul_load),
      .A       (A),
      .B       (B),
      .Busy    (mul_busy),
      .Done    (mul_done),
      .Product (mul_prod)
   );

   assign mul_flags = '{v: 1'b0, c: |mul_prod[2*WIDTH-1:WIDTH],
                        n: mul_prod[WIDTH-1], z: (mul_prod[WIDTH-1:0] == '0)};
`endif

   always_comb begin
      state_d  = state_q;
      alu_load = 1'b0;
`ifdef ALU_MUL_EN
      mul_load = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (Start) begin
`ifdef ALU_MUL_EN
               if (Op == OP_MUL) begin
                  mul_load = 1'b1;
                  state_d  = ST_MUL_RUN;
               end else
`endif
               alu_load = 1'b1;
            end
         end
         ST_MUL_RUN: begin
`ifdef ALU_MUL_EN
            if (mul_done || !mul_busy) begin
               state_d = ST_IDLE;
            end
`else
            state_d = ST_IDLE;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q   <= ST_IDLE;
         alu_out_q <= '0;
         flags_q   <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= 1'b0;
         if (alu_load) begin
            alu_out_q <= res;
            flags_q   <= alu_flags;
            done_q    <= 1'b1;
         end
`ifdef ALU_MUL_EN
         if ((state_q == ST_MUL_RUN) && mul_done) begin
            alu_out_q <= mul_prod[WIDTH-1:0];
            flags_q   <= mul_flags;
            done_q    <= 1'b1;
         end
`endif
      end
   end

   assign Busy     = (state_q == ST_MUL_RUN);
   assign Ready    = !Busy;
   assign Done     = done_q;
   assign ALUOut   = alu_out_q;
   assign Flags    = flags_q;
   assign DbgState = state_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core (WIDTH=16); MUL checks follow ALU_MUL_EN.
module tb_alu_seq_core;
   import alu_seq_pkg::*;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        Start = 1'b0;
   op_t         Op = OP_ADD;
   logic [15:0] A = '0;
   logic [15:0] B = '0;
   logic [3:0]  ShAmt = '0;
   logic        CIn = 1'b0;
   logic        Ready, Busy, Done;
   logic [15:0] ALUOut;
   logic [3:0]  Flags;
   state_t      DbgState;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      op_t         op;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  sh;
      logic        cin;
      logic [15:0] er;
      logic [3:0]  ef;
   } vec_t;

   alu_seq_core #(.WIDTH(16)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Start    (Start),
      .Op       (Op),
      .A        (A),
      .B        (B),
      .ShAmt    (ShAmt),
      .CIn      (CIn),
      .Ready    (Ready),
      .Busy     (Busy),
      .Done     (Done),
      .ALUOut   (ALUOut),
      .Flags    (Flags),
      .DbgState (DbgState)
   );

   always #5 Clock = ~Clock;

   // Called at posedge+1: presents one request, returns at posedge+1 after the accepting edge.
   task automatic drive_start(input op_t op, input logic [15:0] a, input logic [15:0] b,
                              input logic [3:0] sh, input logic cin);
      Op = op; A = a; B = b; ShAmt = sh; CIn = cin; Start = 1'b1;
      @(posedge Clock); #1;
      Start = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (2) @(posedge Clock);
      #1;
      Reset = 1'b0;
      n_cmp++;
      if ({ALUOut, Flags, Done, Busy, Ready} !== {16'h0, 4'h0, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset: out=%h flags=%h done=%b busy=%b ready=%b, want 0000 0 0 0 1",
                  ALUOut, Flags, Done, Busy, Ready);
      end
   endtask

   task automatic run_table(input string tag, input vec_t vecs[$]);
      foreach (vecs[i]) begin
         drive_start(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].cin);
         n_cmp++;
         if ({Done, ALUOut, Flags} !== {1'b1, vecs[i].er, vecs[i].ef}) begin
            n_fail++;
            $display("FAIL %s[%0d] op=%0d: done=%b out=%h flags=%h, want done=1 out=%h flags=%h",
                     tag, i, vecs[i].op, Done, ALUOut, Flags, vecs[i].er, vecs[i].ef);
         end
      end
   endtask

   task automatic test_arith();
      vec_t v[$];
      v.push_back('{OP_ADD, 16'd5,    16'd17,   4'd0, 1'b0, 16'h0016, 4'h0});
      v.push_back('{OP_ADC, 16'd5,    16'd17,   4'd0, 1'b1, 16'h0017, 4'h0});
      v.push_back('{OP_SUB, 16'd5,    16'd17,   4'd0, 1'b0, 16'hFFF4, 4'h2});
      v.push_back('{OP_SBC, 16'd5,    16'd17,   4'd0, 1'b1, 16'hFFF4, 4'h2});
      v.push_back('{OP_SBC, 16'd5,    16'd17,   4'd0, 1'b0, 16'hFFF3, 4'h2});
      v.push_back('{OP_ADD, 16'h7FFF, 16'h0001, 4'd0, 1'b0, 16'h8000, 4'hA});
      v.push_back('{OP_ADD, 16'hFFFF, 16'h0001, 4'd0, 1'b0, 16'h0000, 4'h5});
      v.push_back('{OP_SUB, 16'h1234, 16'h1234, 4'd0, 1'b0, 16'h0000, 4'h5});
      run_table("arith", v);
   endtask

   task automatic test_logic();
      vec_t v[$];
      v.push_back('{OP_AND,  16'hF0F0, 16'h0FF0, 4'd0, 1'b0, 16'h00F0, 4'h0});
      v.push_back('{OP_OR,   16'hF0F0, 16'h0FF0, 4'd0, 1'b0, 16'hFFF0, 4'h2});
      v.push_back('{OP_XOR,  16'hF0F0, 16'h0FF0, 4'd0, 1'b0, 16'hFF00, 4'h2});
      v.push_back('{OP_NOT,  16'hFFFF, 16'h1234, 4'd0, 1'b1, 16'h0000, 4'h1});
      v.push_back('{OP_NAND, 16'hFFFF, 16'hFFFF, 4'd0, 1'b0, 16'h0000, 4'h1});
      v.push_back('{OP_NOR,  16'h0000, 16'h0000, 4'd0, 1'b0, 16'hFFFF, 4'h2});
      v.push_back('{OP_LLI,  16'hAB00, 16'h0043, 4'd0, 1'b0, 16'hAB43, 4'h2});
      v.push_back('{OP_RSVD, 16'h1234, 16'h5678, 4'd0, 1'b1, 16'h0000, 4'h1});
      run_table("logic", v);
   endtask

   task automatic test_shift();
      vec_t v[$];
      v.push_back('{OP_SHL, 16'h0005, 16'h0, 4'd15, 1'b0, 16'h8000, 4'h2});
      v.push_back('{OP_ASR, 16'hFFE9, 16'h0, 4'd15, 1'b0, 16'hFFFF, 4'h6});
      v.push_back('{OP_SHR, 16'hFFE9, 16'h0, 4'd15, 1'b0, 16'h0001, 4'h4});
      v.push_back('{OP_SHL, 16'hFFE9, 16'h0, 4'd0,  1'b0, 16'hFFE9, 4'h2});
      v.push_back('{OP_ASR, 16'hFFE9, 16'h0, 4'd0,  1'b0, 16'hFFE9, 4'h2});
      v.push_back('{OP_SHR, 16'h00F0, 16'h0, 4'd4,  1'b0, 16'h000F, 4'h0});
      v.push_back('{OP_SHL, 16'h8001, 16'h0, 4'd1,  1'b0, 16'h0002, 4'h4});
      v.push_back('{OP_ASR, 16'h4008, 16'h0, 4'd4,  1'b0, 16'h0400, 4'h4});
      run_table("shift", v);
   endtask

   task automatic test_back_to_back();
      Op = OP_AND; A = 16'hF0F0; B = 16'h0FF0; ShAmt = '0; CIn = 1'b0; Start = 1'b1;
      @(posedge Clock); #1;
      n_cmp++;
      if ({Done, ALUOut} !== {1'b1, 16'h00F0}) begin
         n_fail++;
         $display("FAIL b2b_and: done=%b out=%h, want 1 00f0", Done, ALUOut);
      end
      Op = OP_OR;
      @(posedge Clock); #1;
      Start = 1'b0;
      n_cmp++;
      if ({Done, ALUOut, Flags} !== {1'b1, 16'hFFF0, 4'h2}) begin
         n_fail++;
         $display("FAIL b2b_or: done=%b out=%h flags=%h, want 1 fff0 2", Done, ALUOut, Flags);
      end
      @(posedge Clock); #1;
      n_cmp++;
      if ({Done, ALUOut, Flags} !== {1'b0, 16'hFFF0, 4'h2}) begin
         n_fail++;
         $display("FAIL hold: done=%b out=%h flags=%h, want 0 fff0 2", Done, ALUOut, Flags);
      end
   endtask

`ifdef ALU_MUL_EN
   task automatic test_mul();
      int edge_n;
      int done_edge;
      drive_start(OP_ADD, 16'd5, 16'd17, 4'd0, 1'b0);
      drive_start(OP_MUL, 16'd300, 16'd300, 4'd0, 1'b0);
      A = 16'hDEAD; B = 16'hBEEF;
      n_cmp++;
      if ({Busy, Ready, Done, ALUOut} !== {1'b1, 1'b0, 1'b0, 16'h0016}) begin
         n_fail++;
         $display("FAIL mul_accept: busy=%b ready=%b done=%b out=%h, want 1 0 0 0016",
                  Busy, Ready, Done, ALUOut);
      end
      edge_n = 0;
      done_edge = 0;
      while (done_edge == 0 && edge_n < 40) begin
         @(posedge Clock); #1;
         edge_n++;
         if (Done) done_edge = edge_n;
         if (edge_n == 2) begin
            Op = OP_ADD; A = 16'd1; B = 16'd1; Start = 1'b1;
         end
         if (edge_n == 4) Start = 1'b0;
      end
      Start = 1'b0;
      n_cmp++;
      if (done_edge != 16) begin
         n_fail++;
         $display("FAIL mul_latency: done after %0d edges, want 16", done_edge);
      end
      n_cmp++;
      if ({ALUOut, Flags} !== {16'h5F90, 4'h4}) begin
         n_fail++;
         $display("FAIL mul_result: out=%h flags=%h, want 5f90 4", ALUOut, Flags);
      end
      repeat (3) begin
         @(posedge Clock); #1;
         n_cmp++;
         if ({Done, Ready, Busy, ALUOut} !== {1'b0, 1'b1, 1'b0, 16'h5F90}) begin
            n_fail++;
            $display("FAIL mul_after: done=%b ready=%b busy=%b out=%h, want 0 1 0 5f90",
                     Done, Ready, Busy, ALUOut);
         end
      end
   endtask
`else
   task automatic test_mul();
      drive_start(OP_MUL, 16'd300, 16'd300, 4'd0, 1'b0);
      n_cmp++;
      if ({Done, Busy, Ready, ALUOut, Flags} !== {1'b1, 1'b0, 1'b1, 16'h0000, 4'h1}) begin
         n_fail++;
         $display("FAIL mul_off: done=%b busy=%b ready=%b out=%h flags=%h, want 1 0 1 0000 1",
                  Done, Busy, Ready, ALUOut, Flags);
      end
   endtask
`endif

   task automatic test_reset_abort();
      int stray;
      drive_start(OP_ADD, 16'd5, 16'd17, 4'd0, 1'b0);
`ifdef ALU_MUL_EN
      drive_start(OP_MUL, 16'd300, 16'd300, 4'd0, 1'b0);
      repeat (4) @(posedge Clock);
      #1;
`endif
      Reset = 1'b1;
      @(posedge Clock); #1;
      Reset = 1'b0;
      n_cmp++;
      if ({ALUOut, Flags, Done, Busy, Ready} !== {16'h0, 4'h0, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL abort: out=%h flags=%h done=%b busy=%b ready=%b, want 0000 0 0 0 1",
                  ALUOut, Flags, Done, Busy, Ready);
      end
      stray = 0;
      repeat (20) begin
         @(posedge Clock); #1;
         if (Done || ALUOut != 16'h0) stray++;
      end
      n_cmp++;
      if (stray != 0) begin
         n_fail++;
         $display("FAIL abort_quiet: %0d cycles with Done or output change, want 0", stray);
      end
      drive_start(OP_ADD, 16'd5, 16'd17, 4'd0, 1'b0);
      n_cmp++;
      if ({Done, ALUOut} !== {1'b1, 16'h0016}) begin
         n_fail++;
         $display("FAIL post_abort: done=%b out=%h, want 1 0016", Done, ALUOut);
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_logic();
      test_shift();
      test_back_to_back();
      test_mul();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_seq_core.md
# alu_seq_core

Parametrised, registered successor to the 16-bit ALU slice datapath. It performs arithmetic, logic, barrel-shift and LLI operations in one cycle, and an iterative shift-add multiply over WIDTH cycles, behind a Start/Ready/Done handshake. Results and flags are registered. It sits between the register-file read ports and the writeback mux of the processor datapath.

## Interface
Parameters:
- WIDTH, 16, datapath width; even, at least 4
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override)

Ports:
- Clock  in  1  system clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- Start  in  1  request; sampled only while Ready=1
- Op  in  4  operation code (alu_seq_pkg::op_t)
- A  in  WIDTH  operand A; also the shift source
- B  in  WIDTH  operand B
- ShAmt  in  SHW  shift amount for SHL/SHR/ASR
- CIn  in  1  carry in for ADC/SBC
- Ready  out  1  high when idle and able to accept Start
- Busy  out  1  high while a multiply iterates
- Done  out  1  single-cycle pulse when ALUOut and Flags are updated
- ALUOut  out  WIDTH  registered result
- Flags  out  4  registered {V,C,N,Z}

## Operation
- Op codes: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 NOT(A), 8 NAND, 9 NOR, 10 SHL, 11 SHR, 12 ASR, 13 LLI, 14 MUL, 15 reserved.
- ADD: A+B. ADC: A+B+CIn. SUB: A+~B+1. SBC: A+~B+CIn. For these ops C = carry out of bit WIDTH-1 (for SUB/SBC, C=1 means no borrow), and V = signed overflow.
- Logic ops: C=0, V=0.
- Shifts use ShAmt in the range 0..WIDTH-1. ShAmt=0 passes A through with C=0. Otherwise C = the last bit shifted out. ASR replicates A[WIDTH-1]. V=0.
- LLI: {A[WIDTH-1:WIDTH/2], B[WIDTH/2-1:0]}, C=0, V=0.
- MUL: result is the low WIDTH bits of unsigned A*B. C=1 if the high half is nonzero. V=0.
- Reserved op: ALUOut=0, Flags={0,0,0,1}.
- For every op: Z = (result==0), N = result[WIDTH-1].
- Operands are captured on the accepting edge. Input changes after that edge have no effect on the operation in flight.

## Timing
- Reset values: ALUOut=0, Flags=0, Done=0, Busy=0, Ready=1. The multiply state is cleared.
- FSM states: IDLE, MUL_RUN.
- IDLE, Start=1, Op≠MUL: ALUOut/Flags update on that edge and Done=1 for one cycle. Latency is 1. Back-to-back Starts give one result per cycle.
- IDLE, Start=1, Op=MUL: go to MUL_RUN. Busy=1 and Ready=0 from the next cycle.
- MUL_RUN runs exactly WIDTH iterations. On the edge that completes iteration WIDTH, ALUOut/Flags load, Done pulses, and the FSM returns to IDLE. Latency is WIDTH edges from the accepting edge.
- Start while Busy is ignored and is not queued.
- Ready is combinational !Busy.
- Reset during MUL_RUN aborts the multiply. ALUOut/Flags clear and Done does not fire.
- ALUOut/Flags hold their values between Done pulses.

## Configuration
- ALU_MUL_EN defined: the MUL op and the alu_mul_seq instance are built.
- ALU_MUL_EN not defined: no multiplier logic and Busy is tied 0. Op=MUL behaves as the reserved op: single cycle, ALUOut=0, Z=1.

## Structure
- Package alu_seq_pkg holds:
  - op_t enum with the codes above
  - flags_t packed struct {V,C,N,Z}
  - FSM state enum
- Sub-module alu_mul_seq (iterative shift-add multiplier) has ports Clock, Reset, Load, A, B, Busy, Done, Product[2*WIDTH-1:0]. It is compiled only under ALU_MUL_EN.
- The single-cycle datapath and result register live in the top module.

## Test plan
All scenarios use WIDTH=16.
- ADD A=5, B=17 -> ALUOut=22, Flags Z=0 N=0 C=0 V=0, Done one cycle after Start.
- SUB A=5, B=17 -> ALUOut=0xFFF4, N=1, C=0. SBC with CIn=1 -> 0xFFF4; SBC with CIn=0 -> 0xFFF3.
- SHL A=5, ShAmt=15 -> 0x8000, C=0. ASR A=0xFFE9, ShAmt=15 -> 0xFFFF, C=1. SHR A=0xFFE9, ShAmt=15 -> 0x0001. ShAmt=0 -> A.
- LLI A=0xAB00, B=0x0043 -> 0xAB43. Back-to-back Starts with AND then OR -> two consecutive Done pulses with correct results.
- MUL A=300, B=300 -> ALUOut=0x5F90, C=1, Done 16 edges after accept. A Start issued while Busy is ignored.
- Reset asserted 5 cycles into a MUL -> ALUOut=0, Flags=0, no Done, Ready=1. Without ALU_MUL_EN, MUL -> ALUOut=0, Z=1, latency 1.
